// File: rtl/pkt_rr_scheduler.sv
// pkt_rr_scheduler
//   Packet-granular weighted round-robin merge of NUM_PORT show-ahead
//   FAST2.0 packet FIFOs (w_pkt-bit words) onto a single output stream.
//   A granted port may send up to QUOTA consecutive packets while others
//   wait; packets are never interleaved. The word type lives in the top two
//   bits (01 header, 11 middle, 10 tail); only the tail code ends a packet.
//
//   Optional feature macro: PKT_RR_SCHED_PKT_CNT_EN
//     defined   -> per-port 32-bit forwarded-packet counters drive pkt_cnt
//     undefined -> no counters are built, pkt_cnt is tied to zero
module pkt_rr_scheduler #(
    parameter int NUM_PORT = 2,
    parameter int QUOTA    = 4,
    parameter int w_pkt    = 134
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_PORT-1:0]       in_empty,
    input  logic [NUM_PORT*w_pkt-1:0] in_q,
    output logic [NUM_PORT-1:0]       in_rdreq,
    input  logic                      pktout_alf,
    output logic                      pktout_data_wr,
    output logic [w_pkt-1:0]          pktout_data,
    output logic [2:0]                cur_port,
    output logic [NUM_PORT*32-1:0]    pkt_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [7:0] QUOTA_MAX = 8'(QUOTA);
    localparam logic [1:0] TYPE_TAIL = 2'b10;

    // Registered state and outputs
    state_t           state_q, state_d;
    logic [2:0]       cur_port_q, cur_port_d;
    logic [7:0]       quota_q, quota_d;
    logic [w_pkt-1:0] data_q, data_d;
    logic             wr_q, wr_d;

    // Per-port views
    logic [w_pkt-1:0]    port_word [NUM_PORT];
    logic [3:0]          port_dist [NUM_PORT];
    logic [NUM_PORT-1:0] port_is_cur;

    // Decode of the currently granted port and the rotating scan
    logic [w_pkt-1:0] cur_word;
    logic             cur_empty;
    logic             rd_fire;
    logic             rd_tail;
    logic             any_req;
    logic             keep_cur;
    logic [2:0]       scan_port;
    logic [3:0]       scan_dist;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORT; gi++) begin : g_port
            localparam logic [3:0] IDX      = 4'(gi);
            localparam logic [3:0] IDX_WRAP = 4'(gi + NUM_PORT);

            assign port_word[gi]   = in_q[gi*w_pkt +: w_pkt];
            assign port_is_cur[gi] = (cur_port_q == 3'(gi));

            // Scan distance from the current port: cur+1 is 1, the current
            // port itself is NUM_PORT so it is only chosen when nobody else
            // is requesting.
            assign port_dist[gi] = (IDX > {1'b0, cur_port_q})
                                 ? (IDX - {1'b0, cur_port_q})
                                 : (IDX_WRAP - {1'b0, cur_port_q});

            // Show-ahead read acknowledge: only the granted port, only while
            // it has a word, only while a packet is in flight.
            assign in_rdreq[gi] = (state_q == SEND) && port_is_cur[gi] && !in_empty[gi];
        end
    endgenerate

    // Select head word and empty flag of the granted port
    always_comb begin
        cur_word  = '0;
        cur_empty = 1'b1;
        for (int i = 0; i < NUM_PORT; i++) begin
            if (port_is_cur[i]) begin
                cur_word  = port_word[i];
                cur_empty = in_empty[i];
            end
        end
    end

    // Rotating scan: nearest non-empty port after cur_port, wrapping to itself
    always_comb begin
        scan_port = cur_port_q;
        scan_dist = 4'hF;
        for (int i = 0; i < NUM_PORT; i++) begin
            if (!in_empty[i] && (port_dist[i] < scan_dist)) begin
                scan_dist = port_dist[i];
                scan_port = 3'(i);
            end
        end
    end

    assign any_req  = |(~in_empty);
    assign keep_cur = !cur_empty && (quota_q < QUOTA_MAX);
    assign rd_fire  = (state_q == SEND) && !cur_empty;
    assign rd_tail  = rd_fire && (cur_word[w_pkt-1 -: 2] == TYPE_TAIL);

    // Next-state: grant in IDLE, forward words in SEND until the tail
    always_comb begin
        state_d    = state_q;
        cur_port_d = cur_port_q;
        quota_d    = quota_q;
        data_d     = data_q;
        wr_d       = 1'b0;
        case (state_q)
            IDLE: begin
                // Almost-full only gates the start of a packet.
                if (!pktout_alf && any_req) begin
                    if (keep_cur) begin
                        quota_d = quota_q + 8'd1;
                    end else begin
                        cur_port_d = scan_port;
                        quota_d    = 8'd1;
                    end
                    state_d = SEND;
                end
            end
            SEND: begin
                // An empty FIFO mid-packet simply stalls; bubbles are legal.
                if (rd_fire) begin
                    data_d = cur_word;
                    wr_d   = 1'b1;
                    if (rd_tail) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Scheduler state and registered output stage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cur_port_q <= 3'd0;
            quota_q    <= 8'd0;
            data_q     <= '0;
            wr_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_port_q <= cur_port_d;
            quota_q    <= quota_d;
            data_q     <= data_d;
            wr_q       <= wr_d;
        end
    end

    assign pktout_data_wr = wr_q;
    assign pktout_data    = data_q;
    assign cur_port       = cur_port_q;

`ifdef PKT_RR_SCHED_PKT_CNT_EN
    generate
        for (gi = 0; gi < NUM_PORT; gi++) begin : g_cnt
            logic [31:0] cnt_q, cnt_d;

            // Count packets whose tail was consumed from this port (wraps)
            always_comb begin
                cnt_d = cnt_q;
                if (rd_tail && port_is_cur[gi]) begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            // Counter register
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    cnt_q <= 32'd0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign pkt_cnt[gi*32 +: 32] = cnt_q;
        end
    endgenerate
`else
    assign pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_pkt_rr_scheduler.sv
// tb_pkt_rr_scheduler: directed self-checking bench for pkt_rr_scheduler.
// Three ports, QUOTA=2. A small show-ahead FIFO model feeds each port.
module tb_pkt_rr_scheduler;

    localparam int NP = 3;
    localparam int QT = 2;
    localparam int W  = 134;

`ifdef PKT_RR_SCHED_PKT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [NP-1:0]   in_empty = '1;
    logic [NP*W-1:0] in_q = '0;
    logic [NP-1:0]   in_rdreq;
    logic            pktout_alf = 1'b0;
    logic            pktout_data_wr;
    logic [W-1:0]    pktout_data;
    logic [2:0]      cur_port;
    logic [NP*32-1:0] pkt_cnt;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [W-1:0] fq0[$];
    logic [W-1:0] fq1[$];
    logic [W-1:0] fq2[$];
    logic [W-1:0] junk;

    logic [W-1:0]  out_w[$];
    int            out_c[$];
    int            rd_c[$];
    logic [NP-1:0] rd_v[$];

    pkt_rr_scheduler #(
        .NUM_PORT (NP),
        .QUOTA    (QT),
        .w_pkt    (W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .in_empty       (in_empty),
        .in_q           (in_q),
        .in_rdreq       (in_rdreq),
        .pktout_alf     (pktout_alf),
        .pktout_data_wr (pktout_data_wr),
        .pktout_data    (pktout_data),
        .cur_port       (cur_port),
        .pkt_cnt        (pkt_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Show-ahead FIFO model: pop on acknowledged read, present new head
    always @(posedge clk) begin
        if (in_rdreq[0] && fq0.size() > 0) junk = fq0.pop_front();
        if (in_rdreq[1] && fq1.size() > 0) junk = fq1.pop_front();
        if (in_rdreq[2] && fq2.size() > 0) junk = fq2.pop_front();
        in_empty[0] <= (fq0.size() == 0);
        in_empty[1] <= (fq1.size() == 0);
        in_empty[2] <= (fq2.size() == 0);
        in_q[0*W +: W] <= (fq0.size() > 0) ? fq0[0] : '0;
        in_q[1*W +: W] <= (fq1.size() > 0) ? fq1[0] : '0;
        in_q[2*W +: W] <= (fq2.size() > 0) ? fq2[0] : '0;
    end

    // Monitor: log every output word and every read acknowledge
    always @(posedge clk) begin
        #1;
        if (pktout_data_wr) begin
            out_w.push_back(pktout_data);
            out_c.push_back(cyc);
            $display("out cyc=%0d type=%b tag=%0d", cyc, pktout_data[W-1 -: 2], pktout_data[31:0]);
        end
        if (in_rdreq != '0) begin
            rd_c.push_back(cyc);
            rd_v.push_back(in_rdreq);
        end
    end

    function automatic logic [1:0] wtype(input int j, input int n);
        if (j == 0) return 2'b01;
        if (j == n - 1) return 2'b10;
        return 2'b11;
    endfunction

    function automatic logic [W-1:0] mkw(input logic [1:0] t, input int p, input int k, input int j);
        logic [W-1:0] w;
        w = '0;
        w[W-1 -: 2] = t;
        w[31:0]     = p * 10000 + k * 100 + j;
        w[127:96]   = 32'hC0DE0000 + j;
        return w;
    endfunction

    function automatic logic [W-1:0] get_out(input int idx);
        if (idx < out_w.size()) return out_w[idx];
        return '0;
    endfunction

    task automatic push_word(input int p, input logic [W-1:0] w);
        case (p)
            0: fq0.push_back(w);
            1: fq1.push_back(w);
            default: fq2.push_back(w);
        endcase
    endtask

    task automatic push_pkt(input int p, input int k, input int n);
        for (int j = 0; j < n; j++) push_word(p, mkw(wtype(j, n), p, k, j));
    endtask

    task automatic clear_logs();
        out_w.delete(); out_c.delete(); rd_c.delete(); rd_v.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        pktout_alf = 1'b0;
        fq0.delete(); fq1.delete(); fq2.delete();
        repeat (2) @(negedge clk);
        clear_logs();
        reset = 1'b1;
    endtask

    task automatic wait_out(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (out_w.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (out_w.size() < n) begin
            failures++;
            $display("FAIL %s_timeout got=%0d words required=%0d", tag, out_w.size(), n);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        push_pkt(0, 0, 2);
        repeat (2) @(negedge clk);
        checks++; if (in_rdreq !== 3'b000) begin failures++; $display("FAIL rst_rdreq got=%b required=000", in_rdreq); end
        checks++; if (pktout_data_wr !== 1'b0) begin failures++; $display("FAIL rst_wr got=%b required=0", pktout_data_wr); end
        checks++; if (pktout_data !== '0) begin failures++; $display("FAIL rst_data got=%h required=0", pktout_data); end
        checks++; if (cur_port !== 3'd0) begin failures++; $display("FAIL rst_cur_port got=%0d required=0", cur_port); end
        checks++; if (pkt_cnt !== '0) begin failures++; $display("FAIL rst_pkt_cnt got=%h required=0", pkt_cnt); end
    endtask

    task automatic test_single();
        int c0;
        do_reset();
        c0 = cyc;
        push_pkt(0, 1, 3);
        wait_out(3, 30, "single");
        checks++; if (rd_c.size() !== 3) begin failures++; $display("FAIL single_rd_count got=%0d required=3", rd_c.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= rd_c.size() || rd_c[i] !== c0 + 2 + i || rd_v[i] !== 3'b001) begin
                failures++;
                $display("FAIL single_rd%0d got=cyc %0d required=cyc %0d vec 001", i, (i < rd_c.size()) ? rd_c[i] : -1, c0 + 2 + i);
            end
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= out_c.size() || out_c[i] !== c0 + 3 + i) begin
                failures++;
                $display("FAIL single_wr_cyc%0d got=%0d required=%0d", i, (i < out_c.size()) ? out_c[i] : -1, c0 + 3 + i);
            end
            checks++;
            if (get_out(i) !== mkw(wtype(i, 3), 0, 1, i)) begin
                failures++;
                $display("FAIL single_word%0d got=%h required=%h", i, get_out(i), mkw(wtype(i, 3), 0, 1, i));
            end
        end
        checks++;
        if (pkt_cnt[0 +: 32] !== (CNT_EN ? 32'd1 : 32'd0)) begin
            failures++; $display("FAIL single_pkt_cnt0 got=%0d required=%0d", pkt_cnt[0 +: 32], CNT_EN ? 1 : 0);
        end
    endtask

    task automatic test_quota();
        int ord_p[7] = '{0, 0, 1, 1, 0, 0, 0};
        int ord_k[7] = '{0, 1, 0, 1, 2, 3, 4};
        int ord_n[7] = '{2, 2, 3, 3, 2, 2, 2};
        int idx;
        do_reset();
        for (int k = 0; k < 5; k++) push_pkt(0, k, 2);
        for (int k = 0; k < 2; k++) push_pkt(1, k, 3);
        wait_out(16, 200, "quota");
        idx = 0;
        for (int i = 0; i < 7; i++) begin
            for (int j = 0; j < ord_n[i]; j++) begin
                checks++;
                if (get_out(idx) !== mkw(wtype(j, ord_n[i]), ord_p[i], ord_k[i], j)) begin
                    failures++;
                    $display("FAIL quota_pkt%0d_word%0d got=%h required=%h", i, j, get_out(idx), mkw(wtype(j, ord_n[i]), ord_p[i], ord_k[i], j));
                end
                idx++;
            end
        end
        checks++;
        if (pkt_cnt[0 +: 32] !== (CNT_EN ? 32'd5 : 32'd0)) begin
            failures++; $display("FAIL quota_pkt_cnt0 got=%0d required=%0d", pkt_cnt[0 +: 32], CNT_EN ? 5 : 0);
        end
        checks++;
        if (pkt_cnt[32 +: 32] !== (CNT_EN ? 32'd2 : 32'd0)) begin
            failures++; $display("FAIL quota_pkt_cnt1 got=%0d required=%0d", pkt_cnt[32 +: 32], CNT_EN ? 2 : 0);
        end
    endtask

    task automatic test_backpressure();
        int d;
        do_reset();
        // Use up port0's quota so the next grant must rotate to port1.
        push_pkt(0, 0, 2);
        push_pkt(0, 1, 2);
        wait_out(4, 50, "bp_setup");
        repeat (2) @(negedge clk);
        pktout_alf = 1'b1;
        clear_logs();
        push_pkt(0, 5, 2);
        push_pkt(1, 0, 4);
        repeat (6) @(negedge clk);
        checks++; if (rd_c.size() !== 0) begin failures++; $display("FAIL bp_no_rdreq got=%0d reads required=0", rd_c.size()); end
        checks++; if (out_w.size() !== 0) begin failures++; $display("FAIL bp_no_output got=%0d words required=0", out_w.size()); end
        pktout_alf = 1'b0;
        d = cyc;
        @(negedge clk);
        checks++; if (cur_port !== 3'd1) begin failures++; $display("FAIL bp_grant_port got=%0d required=1", cur_port); end
        checks++; if (in_rdreq !== 3'b010) begin failures++; $display("FAIL bp_grant_rdreq got=%b required=010", in_rdreq); end
        checks++;
        if (rd_c.size() == 0 || rd_c[0] !== d + 1) begin
            failures++; $display("FAIL bp_grant_cyc got=%0d required=%0d", (rd_c.size() > 0) ? rd_c[0] : -1, d + 1);
        end
        @(negedge clk);
        pktout_alf = 1'b1;
        repeat (12) @(negedge clk);
        checks++; if (out_w.size() !== 4) begin failures++; $display("FAIL bp_pkt_complete got=%0d words required=4", out_w.size()); end
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (get_out(j) !== mkw(wtype(j, 4), 1, 0, j)) begin
                failures++; $display("FAIL bp_word%0d got=%h required=%h", j, get_out(j), mkw(wtype(j, 4), 1, 0, j));
            end
        end
        pktout_alf = 1'b0;
    endtask

    task automatic test_underflow();
        int c0;
        int first_p0;
        do_reset();
        c0 = cyc;
        push_word(1, mkw(2'b01, 1, 7, 0));
        repeat (3) @(negedge clk);
        push_pkt(0, 8, 2);
        repeat (3) @(negedge clk);
        push_word(1, mkw(2'b11, 1, 7, 1));
        push_word(1, mkw(2'b10, 1, 7, 2));
        wait_out(5, 60, "uflow");
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (get_out(j) !== mkw(wtype(j, 3), 1, 7, j)) begin
                failures++; $display("FAIL uflow_word%0d got=%h required=%h", j, get_out(j), mkw(wtype(j, 3), 1, 7, j));
            end
        end
        checks++;
        if (out_c.size() < 3 || out_c[0] !== c0 + 3 || out_c[1] !== c0 + 8 || out_c[2] !== c0 + 9) begin
            failures++;
            $display("FAIL uflow_wr_cycles got=%0d,%0d,%0d required=%0d,%0d,%0d",
                     (out_c.size() > 0) ? out_c[0] - c0 : -1, (out_c.size() > 1) ? out_c[1] - c0 : -1,
                     (out_c.size() > 2) ? out_c[2] - c0 : -1, 3, 8, 9);
        end
        first_p0 = -1;
        for (int i = rd_c.size() - 1; i >= 0; i--) if (rd_v[i][0]) first_p0 = rd_c[i];
        checks++;
        if (first_p0 !== c0 + 10) begin
            failures++; $display("FAIL uflow_port0_grant got=%0d required=%0d", first_p0 - c0, 10);
        end
        for (int j = 0; j < 2; j++) begin
            checks++;
            if (get_out(3 + j) !== mkw(wtype(j, 2), 0, 8, j)) begin
                failures++; $display("FAIL uflow_p0_word%0d got=%h required=%h", j, get_out(3 + j), mkw(wtype(j, 2), 0, 8, j));
            end
        end
    endtask

    task automatic test_reset_mid();
        int c1;
        do_reset();
        push_pkt(1, 9, 5);
        repeat (3) @(negedge clk);
        checks++; if (cur_port !== 3'd1) begin failures++; $display("FAIL rmid_pre_cur_port got=%0d required=1", cur_port); end
        checks++; if (in_rdreq !== 3'b010) begin failures++; $display("FAIL rmid_pre_rdreq got=%b required=010", in_rdreq); end
        reset = 1'b0;
        #1;
        checks++; if (in_rdreq !== 3'b000) begin failures++; $display("FAIL rmid_rdreq got=%b required=000", in_rdreq); end
        checks++; if (pktout_data_wr !== 1'b0) begin failures++; $display("FAIL rmid_wr got=%b required=0", pktout_data_wr); end
        checks++; if (pktout_data !== '0) begin failures++; $display("FAIL rmid_data got=%h required=0", pktout_data); end
        checks++; if (cur_port !== 3'd0) begin failures++; $display("FAIL rmid_cur_port got=%0d required=0", cur_port); end
        fq0.delete(); fq1.delete(); fq2.delete();
        repeat (2) @(negedge clk);
        clear_logs();
        reset = 1'b1;
        c1 = cyc;
        push_pkt(1, 10, 3);
        wait_out(3, 30, "rmid");
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (get_out(j) !== mkw(wtype(j, 3), 1, 10, j)) begin
                failures++; $display("FAIL rmid_word%0d got=%h required=%h", j, get_out(j), mkw(wtype(j, 3), 1, 10, j));
            end
        end
        checks++;
        if (out_c.size() == 0 || out_c[0] !== c1 + 3) begin
            failures++; $display("FAIL rmid_first_wr got=%0d required=%0d", (out_c.size() > 0) ? out_c[0] - c1 : -1, 3);
        end
        checks++;
        if (pkt_cnt[32 +: 32] !== (CNT_EN ? 32'd1 : 32'd0)) begin
            failures++; $display("FAIL rmid_pkt_cnt1 got=%0d required=%0d", pkt_cnt[32 +: 32], CNT_EN ? 1 : 0);
        end
    endtask

    task automatic test_back_to_back();
        int c0;
        int rel[6] = '{3, 4, 6, 7, 9, 10};
        do_reset();
        c0 = cyc;
        for (int k = 0; k < QT + 1; k++) push_pkt(2, k, 2);
        wait_out(6, 80, "b2b");
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (get_out(i) !== mkw(wtype(i % 2, 2), 2, i / 2, i % 2)) begin
                failures++; $display("FAIL b2b_word%0d got=%h required=%h", i, get_out(i), mkw(wtype(i % 2, 2), 2, i / 2, i % 2));
            end
            checks++;
            if (i >= out_c.size() || out_c[i] !== c0 + rel[i]) begin
                failures++; $display("FAIL b2b_wr_cyc%0d got=%0d required=%0d", i, (i < out_c.size()) ? out_c[i] - c0 : -1, rel[i]);
            end
        end
        checks++; if (cur_port !== 3'd2) begin failures++; $display("FAIL b2b_cur_port got=%0d required=2", cur_port); end
        checks++;
        if (pkt_cnt[64 +: 32] !== (CNT_EN ? 32'd3 : 32'd0)) begin
            failures++; $display("FAIL b2b_pkt_cnt2 got=%0d required=%0d", pkt_cnt[64 +: 32], CNT_EN ? 3 : 0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_quota();
        test_backpressure();
        test_underflow();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
